// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared types and layer table for the LeNet layer sequencer.
package cnn_layer_sequencer_pkg;

  // Loop-nest geometry: level 0 is the fastest-moving counter.
  localparam int CW         = 5;
  localparam int N_LVL      = 6;
  localparam int N_ACC      = 3;   // kx, ky, ic form one accumulation group
  localparam int L_KX       = 0;
  localparam int L_KY       = 1;
  localparam int L_IC       = 2;
  localparam int L_OX       = 3;
  localparam int L_OY       = 4;
  localparam int L_OC       = 5;
  localparam int MAX_LAYERS = 4;

  typedef enum logic {OP_CONV = 1'b0, OP_POOL = 1'b1} op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_WB, S_DONE} state_e;

  typedef struct packed {
    op_e        op;
    logic [4:0] cin;
    logic [4:0] cout;
    logic [4:0] hout;
    logic [4:0] wout;
    logic [2:0] k;
    logic [1:0] stride;
  } layer_cfg_t;

  localparam layer_cfg_t LAYER_CFG [MAX_LAYERS] = '{
    '{op: OP_CONV, cin: 5'd1, cout: 5'd6,  hout: 5'd24, wout: 5'd24, k: 3'd5, stride: 2'd1},
    '{op: OP_POOL, cin: 5'd6, cout: 5'd6,  hout: 5'd12, wout: 5'd12, k: 3'd2, stride: 2'd2},
    '{op: OP_CONV, cin: 5'd6, cout: 5'd16, hout: 5'd8,  wout: 5'd8,  k: 3'd5, stride: 2'd1},
    '{op: OP_POOL, cin: 5'd16, cout: 5'd16, hout: 5'd4, wout: 5'd4,  k: 3'd2, stride: 2'd2}
  };

  // One engine step as seen on the command bus.
  typedef struct packed {
    logic [1:0] layer;
    op_e        op;
    logic [3:0] oc;
    logic [4:0] oy;
    logic [4:0] ox;
    logic [2:0] ic;
    logic [2:0] ky;
    logic [2:0] kx;
    logic [4:0] iy;
    logic [4:0] ix;
    logic       first;
    logic       last;
    logic [4:0] shift;
  } cmd_t;

  function automatic int clog2_i(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Requant shift covers the full accumulator growth of a conv output.
  function automatic logic [4:0] calc_shift(input int width, input layer_cfg_t c);
    return 5'(width + clog2_i(int'(c.cin) * int'(c.k) * int'(c.k)) + 1);
  endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Command bus between the sequencer and the MAC/compare engine.
interface cnn_layer_sequencer_if;
  import cnn_layer_sequencer_pkg::*;

  logic valid;
  logic ready;
  cmd_t cmd;

  modport master (output valid, output cmd, input ready);
  modport slave  (input valid, input cmd, output ready);
endinterface

// File: rtl/cnn_layer_sequencer_nest.sv
// Six-level counter nest with per-level limits. o_nxt is the value the
// counters take at the next edge, so downstream registers can stay aligned.
module cnn_layer_sequencer_nest
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int LVLS = N_LVL,
  parameter int W    = CW,
  parameter int ACC  = N_ACC
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_adv,
  input  logic [LVLS-1:0][W-1:0]   i_lim,
  output logic [LVLS-1:0][W-1:0]   o_cnt,
  output logic [LVLS-1:0][W-1:0]   o_nxt,
  output logic                     o_nxt_first,
  output logic                     o_nxt_last,
  output logic                     o_wrap_all
);

  logic [LVLS-1:0][W-1:0] r_cnt;
  logic [LVLS-1:0]        w_at_max;
  logic [LVLS-1:0]        w_carry;
  logic [ACC-1:0]         w_nf;
  logic [ACC-1:0]         w_nl;

  for (genvar g = 0; g < LVLS; g++) begin : g_lvl
    assign w_at_max[g] = (r_cnt[g] == i_lim[g] - W'(1));
    // A level steps only when every faster level is wrapping.
    if (g == 0) begin : g_c0
      assign w_carry[g] = 1'b1;
    end else begin : g_cn
      assign w_carry[g] = &w_at_max[g-1:0];
    end
    assign o_nxt[g] = i_clear ? '0 :
                      (i_adv && w_carry[g]) ? (w_at_max[g] ? '0 : r_cnt[g] + W'(1)) :
                      r_cnt[g];
  end

  for (genvar g = 0; g < ACC; g++) begin : g_acc
    assign w_nf[g] = (o_nxt[g] == '0);
    assign w_nl[g] = (o_nxt[g] == i_lim[g] - W'(1));
  end

  assign o_nxt_first = &w_nf;
  assign o_nxt_last  = &w_nl;
  assign o_wrap_all  = &w_at_max;
  assign o_cnt       = r_cnt;

  // Counter state.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= o_nxt;
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences the four LeNet layers onto one MAC/compare engine, one command
// per step, pausing for engine writeback between layers.
module cnn_layer_sequencer
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_LAYERS = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_layer_done,
  input  logic                          i_wb_done,
  cnn_layer_sequencer_if.master         o_cmd
);

  localparam logic [1:0] LAST_LAYER = 2'(N_LAYERS - 1);

  state_e                 r_state, w_state_nxt;
  logic [1:0]             r_layer, w_nxt_layer;
  logic                   r_valid, w_valid_nxt;
  logic                   w_clear, w_adv, w_hs;
  logic                   w_wrap_all, w_nxt_first, w_nxt_last;
  logic [N_LVL-1:0][CW-1:0] w_lim, w_cnt, w_nxt;
  layer_cfg_t             w_cfg;
  logic [4:0]             w_shift_tab [MAX_LAYERS];
  logic [4:0]             w_iy_nxt, w_ix_nxt, w_oy_s, w_ox_s, w_shift_nxt;
  op_e                    r_op;
  logic [4:0]             r_iy, r_ix, r_shift;
  logic                   r_first, r_last;
  cmd_t                   w_cmd;
  logic                   w_unused;

  for (genvar l = 0; l < MAX_LAYERS; l++) begin : g_shift
    assign w_shift_tab[l] = calc_shift(WIDTH, LAYER_CFG[l]);
  end

  // Layer the counters will belong to after this edge; limits follow it so
  // the flags computed on a layer change use the new geometry.
  always_comb begin
    w_nxt_layer = r_layer;
    if (r_state == S_IDLE && i_start)
      w_nxt_layer = '0;
    else if (r_state == S_WAIT_WB && i_wb_done && r_layer != LAST_LAYER)
      w_nxt_layer = r_layer + 2'd1;
  end

  assign w_cfg        = LAYER_CFG[w_nxt_layer];
  assign w_lim[L_KX]  = {2'b0, w_cfg.k};
  assign w_lim[L_KY]  = {2'b0, w_cfg.k};
  assign w_lim[L_IC]  = (w_cfg.op == OP_POOL) ? 5'd1 : w_cfg.cin;
  assign w_lim[L_OX]  = w_cfg.wout;
  assign w_lim[L_OY]  = w_cfg.hout;
  assign w_lim[L_OC]  = w_cfg.cout;

  cnn_layer_sequencer_nest #(.LVLS(N_LVL), .W(CW), .ACC(N_ACC)) u_nest (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_clear),
    .i_adv       (w_adv),
    .i_lim       (w_lim),
    .o_cnt       (w_cnt),
    .o_nxt       (w_nxt),
    .o_nxt_first (w_nxt_first),
    .o_nxt_last  (w_nxt_last),
    .o_wrap_all  (w_wrap_all)
  );

  // Input coordinates: stride is 1 (conv) or 2 (pool).
  assign w_oy_s      = (w_cfg.stride == 2'd2) ? {w_nxt[L_OY][3:0], 1'b0} : w_nxt[L_OY];
  assign w_ox_s      = (w_cfg.stride == 2'd2) ? {w_nxt[L_OX][3:0], 1'b0} : w_nxt[L_OX];
  assign w_iy_nxt    = w_oy_s + w_nxt[L_KY];
  assign w_ix_nxt    = w_ox_s + w_nxt[L_KX];
  assign w_shift_nxt = (w_cfg.op == OP_CONV && w_nxt_last) ? w_shift_tab[w_nxt_layer] : 5'd0;

  assign w_hs = r_valid && o_cmd.ready;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, counter control and the layer_done strobe.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_clear      = 1'b0;
    w_adv        = 1'b0;
    o_layer_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_clear     = 1'b1;
          w_valid_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (w_hs) begin
          if (w_wrap_all) begin
            w_state_nxt  = S_WAIT_WB;
            w_valid_nxt  = 1'b0;
            o_layer_done = 1'b1;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      S_WAIT_WB: begin
        if (i_wb_done) begin
          if (r_layer == LAST_LAYER) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
            w_clear     = 1'b1;
            w_valid_nxt = 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command fields derived from the next counter values, loaded with them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_layer <= '0;
      r_op    <= OP_CONV;
      r_iy    <= '0;
      r_ix    <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_shift <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_layer <= w_nxt_layer;
      if (w_clear || w_adv) begin
        r_op    <= w_cfg.op;
        r_iy    <= w_iy_nxt;
        r_ix    <= w_ix_nxt;
        r_first <= w_nxt_first;
        r_last  <= w_nxt_last;
        r_shift <= w_shift_nxt;
      end
    end
  end

  // Pack the bus; coordinates come straight from the counter registers.
  always_comb begin
    w_cmd       = '0;
    w_cmd.layer = r_layer;
    w_cmd.op    = r_op;
    w_cmd.oc    = w_cnt[L_OC][3:0];
    w_cmd.oy    = w_cnt[L_OY];
    w_cmd.ox    = w_cnt[L_OX];
    w_cmd.ic    = w_cnt[L_IC][2:0];
    w_cmd.ky    = w_cnt[L_KY][2:0];
    w_cmd.kx    = w_cnt[L_KX][2:0];
    w_cmd.iy    = r_iy;
    w_cmd.ix    = r_ix;
    w_cmd.first = r_first;
    w_cmd.last  = r_last;
    w_cmd.shift = r_shift;
  end

  assign o_cmd.valid = r_valid;
  assign o_cmd.cmd   = w_cmd;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

  // Counter bits above the bus field widths never become nonzero.
  assign w_unused = ^{w_cnt[L_OC][4], w_cnt[L_IC][4:3], w_cnt[L_KY][4:3],
                      w_cnt[L_KX][4:3], w_nxt[L_OC], w_nxt[L_IC]};

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Randomized bench: every accepted command is compared with a reference
// computed by decomposing the per-layer command index.
`timescale 1ns/1ps
module tb_cnn_layer_sequencer;
  import cnn_layer_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic wb_done = 1'b0;
  logic busy, done, layer_done;

  cnn_layer_sequencer_if cif();

  cnn_layer_sequencer #(.WIDTH(8), .N_LAYERS(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_layer_done (layer_done),
    .i_wb_done    (wb_done),
    .o_cmd        (cif)
  );

  always #5 clk = ~clk;

  // Network geometry: kernel, effective input channels, out size, stride.
  localparam int K_T  [4] = '{5, 2, 5, 2};
  localparam int CE_T [4] = '{1, 1, 6, 1};
  localparam int HW_T [4] = '{24, 12, 8, 4};
  localparam int CO_T [4] = '{6, 6, 16, 16};
  localparam int S_T  [4] = '{1, 2, 1, 2};
  localparam int P_T  [4] = '{0, 1, 0, 1};
  localparam int SH_T [4] = '{14, 0, 17, 0};
  localparam int CNT_SPEC [4] = '{86400, 3456, 153600, 1024};
  localparam int CYC_MAX = 400000;

  int n_tests = 0;
  int n_fail  = 0;
  int seen [4];
  int ldone_cnt, done_cnt, viol_stable, viol_wb;
  bit finished, timed_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int per_layer(input int l);
    return CO_T[l] * HW_T[l] * HW_T[l] * CE_T[l] * K_T[l] * K_T[l];
  endfunction

  function automatic cmd_t exp_cmd(input int l, input int n);
    cmd_t c;
    int r, kx, ky, ic, ox, oy, oc, grp;
    r  = n;
    kx = r % K_T[l];   r = r / K_T[l];
    ky = r % K_T[l];   r = r / K_T[l];
    ic = r % CE_T[l];  r = r / CE_T[l];
    ox = r % HW_T[l];  r = r / HW_T[l];
    oy = r % HW_T[l];
    oc = r / HW_T[l];
    grp = CE_T[l] * K_T[l] * K_T[l];
    c       = '0;
    c.layer = 2'(l);
    c.op    = op_e'(P_T[l]);
    c.oc    = 4'(oc);
    c.oy    = 5'(oy);
    c.ox    = 5'(ox);
    c.ic    = 3'(ic);
    c.ky    = 3'(ky);
    c.kx    = 3'(kx);
    c.iy    = 5'(S_T[l] * oy + ky);
    c.ix    = 5'(S_T[l] * ox + kx);
    c.first = ((n % grp) == 0);
    c.last  = ((n % grp) == grp - 1);
    c.shift = c.last ? 5'(SH_T[l]) : 5'd0;
    return c;
  endfunction

  // Drive one network run; stop early after command stop_n of layer stop_l.
  task automatic run_net(input bit rnd, input int stop_l, input int stop_n);
    int   l, n, wb_wait, stall, sb_err, cyc, f0;
    bit   pend, waiting, wb_fire;
    cmd_t prev, cur, e;
    l = 0; n = 0; wb_wait = -1; stall = 0; sb_err = 0; cyc = 0;
    pend = 0; waiting = 0; prev = '0;
    for (int i = 0; i < 4; i++) seen[i] = 0;
    ldone_cnt = 0; done_cnt = 0; viol_stable = 0; viol_wb = 0; finished = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_valid", cif.valid, 1);
    while (!finished && cyc < CYC_MAX) begin
      wb_done = 1'b0;
      wb_fire = 1'b0;
      if (wb_wait == 0) begin
        wb_done = 1'b1; wb_fire = 1'b1; wb_wait = -1;
      end else if (wb_wait > 0) begin
        wb_wait--;
      end else if (rnd && !waiting && $urandom_range(63) == 0) begin
        wb_done = 1'b1;  // stray pulse outside WAIT_WB
      end
      start = rnd && ($urandom_range(127) == 0);
      if (stall > 0) begin
        cif.ready = 1'b0; stall--;
      end else begin
        cif.ready = rnd ? ($urandom_range(15) != 0) : 1'b1;
      end
      #1;
      cur = cif.cmd;
      if (pend && (!cif.valid || cur != prev)) viol_stable++;
      pend = cif.valid && !cif.ready;
      prev = cur;
      if (waiting && cif.valid) viol_wb++;
      if (wb_fire) waiting = 0;
      if (layer_done) ldone_cnt++;
      if (done) begin done_cnt++; finished = 1; end
      if (cif.valid && cif.ready && l < 4) begin
        e = exp_cmd(l, n);
        if (sb_err < 8) begin
          f0 = n_fail;
          chk($sformatf("cmd_l%0d_n%0d", l, n), cur, e);
          chk($sformatf("ldone_l%0d_n%0d", l, n), layer_done, (n == per_layer(l) - 1));
          if (n_fail != f0) sb_err++;
        end
        if (l == 0 && n == 24) begin
          chk("c25_ky", cur.ky, 4);
          chk("c25_kx", cur.kx, 4);
          chk("c25_last", cur.last, 1);
          chk("c25_shift", cur.shift, 14);
        end
        if (l == 0 && n == 25) begin
          chk("c26_ox", cur.ox, 1);
          chk("c26_ix", cur.ix, 1);
          chk("c26_first", cur.first, 1);
        end
        if (l == 1 && n == 1318) begin
          chk("pool_oc", cur.oc, 2);
          chk("pool_oy", cur.oy, 3);
          chk("pool_ox", cur.ox, 5);
          chk("pool_iy", cur.iy, 7);
          chk("pool_ix", cur.ix, 10);
          chk("pool_op", cur.op, 1);
          chk("pool_shift", cur.shift, 0);
        end
        if (rnd && l == 0 && n == 99) stall = 7;
        seen[l]++;
        n++;
        if (n == per_layer(l)) begin
          l++; n = 0; waiting = 1;
          wb_wait = rnd ? int'($urandom_range(20)) : 0;
        end
        if (l == stop_l && n == stop_n) finished = 1;
      end
      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    timed_out = !finished;
    start   = 1'b0;
    wb_done = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    cif.ready = 1'b0;
    // Reset held with start asserted.
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", cif.valid, 0);
      chk("rst_done", done, 0);
    end
    chk("rst_cmd", cif.cmd, '0);
    chk("rst_ldone", layer_done, 0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // Full randomized run.
    run_net(1'b1, -1, -1);
    chk("A_timeout", timed_out, 0);
    for (int l = 0; l < 4; l++) chk($sformatf("A_count_l%0d", l), seen[l], CNT_SPEC[l]);
    chk("A_layer_done_pulses", ldone_cnt, 4);
    chk("A_done_pulses", done_cnt, 1);
    chk("A_backpressure_stable", viol_stable, 0);
    chk("A_wait_wb_valid", viol_wb, 0);
    @(posedge clk); #1;
    chk("A_idle_busy", busy, 0);
    chk("A_idle_valid", cif.valid, 0);
    chk("A_idle_done", done, 0);

    // Reset during layer 2, then restart.
    run_net(1'b0, 2, 500);
    chk("B_reached_l2", timed_out, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("B_rst_busy", busy, 0);
    chk("B_rst_valid", cif.valid, 0);
    chk("B_rst_done", done, 0);
    chk("B_rst_cmd", cif.cmd, '0);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    chk("B_no_done_after_rst", dn, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("B_restart_valid", cif.valid, 1);
    chk("B_restart_cmd", cif.cmd, exp_cmd(0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
